// File: rtl/text_console_writer_pkg.sv
// ---------------------------------------------------------------------------
// text_console_writer_pkg
//   Shared constants for the 80x25 text-mode console: screen geometry, VRAM
//   address width, blank fill character, control codes and the writer FSM
//   state encoding. The VGA adapter uses the same geometry constants for its
//   scan-out address calculation.
// ---------------------------------------------------------------------------
package text_console_writer_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int ADDR_W = 12;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  // Byte offsets inside VRAM (two bytes per cell: char, attr)
  localparam logic [ADDR_W-1:0] ROW_BYTES   = ADDR_W'(2 * COLS);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(2 * COLS * ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CHAR = 3'd1,
    ST_WR_ATTR = 3'd2,
    ST_SCR_RD  = 3'd3,
    ST_SCR_WR  = 3'd4,
    ST_FILL    = 3'd5
  } state_t;

  // True for the control codes the writer interprets; everything else prints.
  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == CC_CR) || (c == CC_LF) || (c == CC_BS) || (c == CC_FF);
  endfunction

endpackage

// File: rtl/text_console_writer_addr_gen.sv
// ---------------------------------------------------------------------------
// console_addr_gen
//   Combinational VRAM byte address of a screen cell: 2*(row*COLS+col).
//   Ports:
//     i_row  [ROW_W]   cell row
//     i_col  [COL_W]   cell column
//     o_addr [ADDR_W]  byte address of the cell's char byte (attr is +1)
// ---------------------------------------------------------------------------
module console_addr_gen
  import text_console_writer_pkg::*;
(
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_col,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_row_ext;
  logic [ADDR_W-1:0] w_col_ext;
  logic [ADDR_W-1:0] w_cell;

  assign w_row_ext = ADDR_W'(i_row);
  assign w_col_ext = ADDR_W'(i_col);

  generate
    if (COLS == 80) begin : g_shift_add
      // row*80 = row*64 + row*16, avoids a multiplier
      assign w_cell = (w_row_ext << 6) + (w_row_ext << 4) + w_col_ext;
    end else begin : g_mult
      assign w_cell = ADDR_W'(w_row_ext * ADDR_W'(COLS)) + w_col_ext;
    end
  endgenerate

  assign o_addr = w_cell << 1;

endmodule

// File: rtl/text_console_writer.sv
// ---------------------------------------------------------------------------
// text_console_writer
//   Writer side of the 80x25 text-mode VRAM. Takes char/attr bytes, writes
//   them at the cursor, interprets CR/LF/BS/FF and scrolls the screen up one
//   row when the cursor runs off the bottom.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     byte handshake; in_char/in_attr latched on accept
//     vram_addr/we/wdata    VRAM read/write port (registered)
//     vram_rdata            VRAM read data, one cycle after the address
//     cursor_col/row        current cursor
//     busy                  any state other than IDLE
//     dbg_state             current FSM state
//
//   Handshake: a byte transfers on a clock edge where in_valid && in_ready.
//   in_ready is high exactly in IDLE and does not depend on in_valid; the
//   producer must hold in_valid/in_char/in_attr stable until that edge.
// ---------------------------------------------------------------------------
module text_console_writer
  import text_console_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  output logic              in_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy,
  output state_t            dbg_state
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [7:0]        r_char;
  logic [7:0]        r_attr;
  logic [ADDR_W-1:0] r_i;

  logic [7:0]        w_cc_char;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic              w_lf;
  logic              w_scroll;
  logic [ROW_W-1:0]  w_ag_row;
  logic [COL_W-1:0]  w_ag_col;
  logic [ADDR_W-1:0] w_ag_addr;
  logic [ADDR_W-1:0] w_i_nxt;

  // Cursor step is evaluated on the incoming byte in IDLE (to send an LF on
  // the last row straight into the scroll) and on the latched byte later.
  assign w_cc_char = (r_state == ST_IDLE) ? in_char : r_char;

  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    w_lf      = 1'b0;
    w_scroll  = 1'b0;
    case (w_cc_char)
      CC_CR: w_col_nxt = '0;
      CC_LF: w_lf = 1'b1;
      CC_BS: if (r_col != '0) w_col_nxt = r_col - 7'd1;
      CC_FF: w_lf = 1'b0;
      default: begin
        if (r_col < COL_W'(COLS - 1)) begin
          w_col_nxt = r_col + 7'd1;
        end else begin
          w_col_nxt = '0;
          w_lf      = 1'b1;
        end
      end
    endcase
    if (w_lf) begin
      if (r_row < ROW_W'(ROWS - 1)) w_row_nxt = r_row + 5'd1;
      else                          w_scroll  = 1'b1;
    end
  end

  // In SCR_WR the generator supplies the start of the last row for the fill.
  assign w_ag_row = (r_state == ST_SCR_WR) ? ROW_W'(ROWS - 1) : r_row;
  assign w_ag_col = (r_state == ST_SCR_WR) ? '0 : r_col;

  console_addr_gen u_addr_gen (
    .i_row  (w_ag_row),
    .i_col  (w_ag_col),
    .o_addr (w_ag_addr)
  );

  assign w_i_nxt = r_i + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_char  <= '0;
      r_attr  <= '0;
      r_i     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we <= 1'b0;
          if (in_valid) begin
            r_char <= in_char;
            r_attr <= in_attr;
            if (in_char == CC_FF) begin
              r_state <= ST_FILL;
              r_i     <= '0;
              r_addr  <= '0;
              r_we    <= 1'b1;
              r_wdata <= BLANK_CHAR;
            end else if (!is_ctrl(in_char)) begin
              r_state <= ST_WR_CHAR;
              r_addr  <= w_ag_addr;
              r_we    <= 1'b1;
              r_wdata <= in_char;
            end else if (w_scroll) begin
              r_state <= ST_SCR_RD;
              r_i     <= '0;
              r_addr  <= ROW_BYTES;
            end else begin
              // Cursor-only code: one cycle in WR_ATTR with the strobe off
              r_state <= ST_WR_ATTR;
            end
          end
        end

        ST_WR_CHAR: begin
          r_state <= ST_WR_ATTR;
          r_addr  <= r_addr + ADDR_W'(1);
          r_we    <= 1'b1;
          r_wdata <= r_attr;
        end

        ST_WR_ATTR: begin
          r_col <= w_col_nxt;
          r_row <= w_row_nxt;
          if (w_scroll) begin
            r_state <= ST_SCR_RD;
            r_i     <= '0;
            r_addr  <= ROW_BYTES;
            r_we    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
          end
        end

        ST_SCR_RD: begin
          r_state <= ST_SCR_WR;
          r_addr  <= r_i;
          r_we    <= 1'b1;
        end

        ST_SCR_WR: begin
          if (r_i == SCROLL_LAST) begin
            r_state <= ST_FILL;
            r_i     <= w_ag_addr;
            r_addr  <= w_ag_addr;
            r_wdata <= BLANK_CHAR;
            r_we    <= 1'b1;
          end else begin
            r_state <= ST_SCR_RD;
            r_i     <= w_i_nxt;
            r_addr  <= w_i_nxt + ROW_BYTES;
            r_we    <= 1'b0;
          end
        end

        ST_FILL: begin
          if (r_i == SCREEN_LAST) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            // FF homes the cursor; a scroll fill leaves it on the last row
            if (r_char == CC_FF) begin
              r_col <= '0;
              r_row <= '0;
            end
          end else begin
            r_i     <= w_i_nxt;
            r_addr  <= w_i_nxt;
            r_wdata <= w_i_nxt[0] ? r_attr : BLANK_CHAR;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign vram_addr  = r_addr;
  assign vram_we    = r_we;
  // Scroll copies the byte read in SCR_RD, which only arrives during SCR_WR
  assign vram_wdata = (r_state == ST_SCR_WR) ? vram_rdata : r_wdata;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;
  import text_console_writer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [7:0]        in_char = '0;
  logic [7:0]        in_attr = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [7:0]        vram_wdata;
  logic [7:0]        vram_rdata;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;
  logic              busy;
  state_t            dbg_state;

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .in_ready   (in_ready),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- VRAM model with backdoor port ----------------
  logic [7:0]  mem    [0:4095];
  logic [7:0]  shadow [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk) begin
    if (bd_we)        mem[bd_addr] <= bd_data;
    else if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  bit sb_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && vram_we) begin
      wr_cnt++;
      check("we_in_idle", {31'b0, in_ready}, 32'd0);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, none expected", vram_addr, vram_wdata);
        end else begin
          e = exp_q.pop_front();
          check("vram_write", {12'b0, vram_addr, vram_wdata}, {12'b0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({a[11:0], d});
    shadow[a] = d;
  endtask

  task automatic bd_write(input int a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = a[11:0];
    bd_data = d;
    shadow[a] = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] at);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char = c;
    in_attr = at;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles with busy high after an accept (bounded).
  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, {25'b0, cursor_col}, col);
    check({name, "_row"}, {27'b0, cursor_row}, row);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int bad;
    int w0;

    // known VRAM contents, loaded while the DUT is held in reset
    for (int k = 0; k < 4096; k++) bd_write(k, 8'(k * 7 + 3));

    // 1. reset state and idle quiet period
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_we", {31'b0, vram_we}, 32'd0);
    check("rst_addr", {20'b0, vram_addr}, 32'd0);
    check("rst_wdata", {24'b0, vram_wdata}, 32'd0);
    check_cursor("rst", 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_writes", wr_cnt, 0);
    check("idle_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});

    // 2. single printable at (0,0)
    push_wr(0, 8'h41);
    push_wr(1, 8'h1F);
    send(8'h41, 8'h1F);
    wait_idle(c);
    check("t2_busy", c, 2);
    check("t2_ready", {31'b0, in_ready}, 32'd1);
    check_cursor("t2", 1, 0);

    // 3. wrap at (79,3), BS at col 0, CR at col 10
    for (int k = 0; k < 3; k++) begin
      send(CC_LF, 8'h00);
      wait_idle(c);
      check("t3_lf_busy", c, 1);
    end
    check_cursor("t3_lf", 1, 3);
    send(CC_CR, 8'h00);
    wait_idle(c);
    check_cursor("t3_cr0", 0, 3);
    for (int k = 0; k < 79; k++) begin
      push_wr(2 * (240 + k), 8'(8'h21 + k));
      push_wr(2 * (240 + k) + 1, 8'h17);
      send(8'(8'h21 + k), 8'h17);
      wait_idle(c);
    end
    check_cursor("t3_row3", 79, 3);
    push_wr(638, 8'h5A);
    push_wr(639, 8'h2E);
    send(8'h5A, 8'h2E);
    wait_idle(c);
    check("t3_z_busy", c, 2);
    check_cursor("t3_wrap", 0, 4);
    send(CC_BS, 8'h00);
    wait_idle(c);
    check("t3_bs_busy", c, 1);
    check_cursor("t3_bs", 0, 4);
    for (int k = 0; k < 10; k++) begin
      push_wr(640 + 2 * k, 8'h61);
      push_wr(641 + 2 * k, 8'h70);
      send(8'h61, 8'h70);
      wait_idle(c);
    end
    check_cursor("t3_col10", 10, 4);
    send(CC_BS, 8'h00);
    wait_idle(c);
    check_cursor("t3_bs9", 9, 4);
    send(CC_CR, 8'h00);
    wait_idle(c);
    check("t3_cr_busy", c, 1);
    check_cursor("t3_cr", 0, 4);

    // 4. scroll on LF at the last row
    for (int k = 0; k < 20; k++) begin
      send(CC_LF, 8'h00);
      wait_idle(c);
    end
    check_cursor("t4_lf", 0, 24);
    for (int k = 0; k < 5; k++) begin
      push_wr(3840 + 2 * k, 8'h62);
      push_wr(3841 + 2 * k, 8'h1E);
      send(8'h62, 8'h1E);
      wait_idle(c);
    end
    check_cursor("t4_pre", 5, 24);
    bd_write(160, 8'h55);
    bd_write(3999, 8'h77);
    for (int i = 0; i < 3840; i++) push_wr(i, shadow[i + 160]);
    for (int i = 3840; i < 4000; i++) push_wr(i, (i % 2 == 1) ? 8'h4E : 8'h20);
    send(CC_LF, 8'h4E);
    wait_idle(c);
    check("t4_busy", c, 7840);
    check_cursor("t4_post", 5, 24);
    check("t4_mem0", {24'b0, mem[0]}, 32'h55);
    check("t4_mem3840", {24'b0, mem[3840]}, 32'h20);
    check("t4_mem3999", {24'b0, mem[3999]}, 32'h4E);
    check("t4_queue", exp_q.size(), 0);

    // 5. form feed clears the screen
    for (int i = 0; i < 4000; i++) push_wr(i, (i % 2 == 1) ? 8'h07 : 8'h20);
    send(CC_FF, 8'h07);
    wait_idle(c);
    check("t5_busy", c, 4000);
    check_cursor("t5", 0, 0);
    bad = 0;
    for (int i = 0; i < 4000; i++)
      if (mem[i] !== ((i % 2 == 1) ? 8'h07 : 8'h20)) bad++;
    check("t5_scan", bad, 0);

    // 6. reset in the middle of a scroll
    for (int k = 0; k < 24; k++) begin
      send(CC_LF, 8'h00);
      wait_idle(c);
    end
    check_cursor("t6_pre", 0, 24);
    sb_on = 1'b0;
    send(CC_LF, 8'h11);
    repeat (999) @(posedge clk);
    #2;
    check("t6_we_before", {31'b0, vram_we}, 32'd1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_we_async", {31'b0, vram_we}, 32'd0);
    check("t6_busy_async", {31'b0, busy}, 32'd0);
    check("t6_ready_async", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("t6_no_writes", wr_cnt - w0, 0);
    check("t6_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check_cursor("t6_post", 0, 0);

    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
